// File: rtl/inst_loader_pkg.sv
// inst_loader_pkg: loader state encoding and instruction-store geometry shared by the loader.
package inst_loader_pkg;
  typedef enum logic [2:0] {IDLE, B0, B1, B2, WRITE, DONE} state_e;
  localparam int BYTES_PER_INST = 3;
  localparam int INST_CAP_DEF = 5;
  function automatic int cap_of(input int cap_w);
    return 1 << cap_w;
  endfunction
  localparam int CAP = cap_of(INST_CAP_DEF);
endpackage

// File: rtl/inst_loader_if.sv
// inst_loader_if: byte stream in and instruction-memory write port out of the loader.
interface inst_loader_if #(parameter int INST_LEN = 17, parameter int INST_CAP = 5);
  logic [7:0]          s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic                im_w_en;
  logic [INST_CAP-1:0] im_w_addr;
  logic [INST_LEN-1:0] im_w_data;
  modport slave (input s_data, s_valid, s_last, output s_ready, im_w_en, im_w_addr, im_w_data);
  modport master (output s_data, s_valid, s_last, input s_ready, im_w_en, im_w_addr, im_w_data);
endinterface

// File: rtl/inst_loader.sv
// inst_loader: assembles 3-byte little-endian instructions from a stream into instruction memory,
// holding the pipeline in reset until a load completes.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int INST_LEN = 17,
  parameter int INST_CAP = INST_CAP_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load_start_i,
  inst_loader_if.slave      bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [INST_CAP:0] count_o,
  output logic              pipe_rstn_o
);
  state_e              state_q, state_d;
  logic [23:0]         asm_q, asm_d;
  logic                last_q, last_d;
  logic [INST_CAP:0]   count_q, count_d;
  logic                busy_q, busy_d, done_q, done_d, err_q, err_d, pipe_q, pipe_d;
  logic                wen_q, wen_d;
  logic [INST_CAP-1:0] waddr_q, waddr_d;
  logic [INST_LEN-1:0] wdata_q, wdata_d;
  logic                xfer, fin;
  assign bus.s_ready = (state_q == B0) || (state_q == B1) || (state_q == B2);
  assign xfer = bus.s_valid && bus.s_ready;
  always_comb begin
    state_d = state_q;
    asm_d = asm_q;
    last_d = last_q;
    count_d = count_q;
    busy_d = busy_q;
    done_d = done_q;
    err_d = err_q;
    pipe_d = pipe_q;
    wen_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    fin = 1'b0;
    case (state_q)
      IDLE, DONE: if (load_start_i) begin
        state_d = B0;
        busy_d = 1'b1;
        done_d = 1'b0;
        err_d = 1'b0;
        count_d = '0;
        pipe_d = 1'b0;
      end
      B0, B1: if (xfer) begin
        if (state_q == B0) asm_d[7:0] = bus.s_data;
        else asm_d[15:8] = bus.s_data;
        state_d = (state_q == B0) ? B1 : B2;
        err_d = err_q | bus.s_last;
        fin = bus.s_last;
      end
      B2: if (xfer) begin
        asm_d[23:16] = bus.s_data;
        // upper byte bits beyond INST_LEN are dropped but flagged
        err_d = err_q | (|(bus.s_data >> (INST_LEN - 16)));
        last_d = bus.s_last;
        wen_d = 1'b1;
        waddr_d = count_q[INST_CAP-1:0];
        wdata_d = asm_d[INST_LEN-1:0];
        state_d = WRITE;
      end
      WRITE: begin
        count_d = count_q + 1'b1;
        fin = last_q || (count_d == (INST_CAP+1)'(cap_of(INST_CAP)));
        err_d = err_q | (!last_q && fin);
        state_d = B0;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      state_d = DONE;
      busy_d = 1'b0;
      done_d = 1'b1;
      pipe_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      asm_q <= '0;
      last_q <= 1'b0;
      count_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      pipe_q <= 1'b0;
      wen_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      asm_q <= asm_d;
      last_q <= last_d;
      count_q <= count_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      pipe_q <= pipe_d;
      wen_q <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign bus.im_w_en = wen_q;
  assign bus.im_w_addr = waddr_q;
  assign bus.im_w_data = wdata_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign err_o = err_q;
  assign count_o = count_q;
  assign pipe_rstn_o = pipe_q;
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: directed loads with hand-computed instruction words and status.
module tb_inst_loader;
  localparam int IL = 17;
  localparam int IC = 5;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic load_start = 1'b0;
  logic busy, done, err, pipe;
  logic [IC:0] count;
  int checks = 0;
  int errors = 0;
  int nw = 0;
  int nx = 0;
  inst_loader_if #(.INST_LEN(IL), .INST_CAP(IC)) ifc ();
  inst_loader #(.INST_LEN(IL), .INST_CAP(IC)) dut (
    .clk(clk), .rstn(rstn), .load_start_i(load_start), .bus(ifc),
    .busy_o(busy), .done_o(done), .err_o(err), .count_o(count), .pipe_rstn_o(pipe)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ifc.s_valid && ifc.s_ready) nx++;
    if (ifc.im_w_en) nw++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input logic l, input int gap);
    int t = 0;
    ifc.s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    ifc.s_valid = 1'b1;
    ifc.s_data = b;
    ifc.s_last = l;
    while (!ifc.s_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) chk("ready_timeout", 32'(t), 32'd0);
    @(posedge clk); #1;
    ifc.s_valid = 1'b0;
    ifc.s_last = 1'b0;
  endtask
  task automatic inst(input logic [7:0] b0, b1, b2, input logic l, input int gap,
                      input logic [IC-1:0] a, input logic [IL-1:0] d);
    send(b0, 1'b0, gap);
    send(b1, 1'b0, gap);
    send(b2, l, gap);
    chk("wen", 32'(ifc.im_w_en), 32'd1);
    chk("waddr", 32'(ifc.im_w_addr), 32'(a));
    chk("wdata", 32'(ifc.im_w_data), 32'(d));
    chk("ready_in_write", 32'(ifc.s_ready), 32'd0);
  endtask
  task automatic status(input string tag, input logic b, dn, e, p, input int c);
    chk({tag, "_busy"}, 32'(busy), 32'(b));
    chk({tag, "_done"}, 32'(done), 32'(dn));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_pipe"}, 32'(pipe), 32'(p));
    chk({tag, "_count"}, 32'(count), 32'(c));
  endtask
  initial begin
    int w0, x0;
    ifc.s_valid = 1'b0;
    ifc.s_data = '0;
    ifc.s_last = 1'b0;
    #2 rstn = 1'b1;
    #1;
    status("rst", 0, 0, 0, 0, 0);
    chk("rst_ready", 32'(ifc.s_ready), 32'd0);
    chk("rst_wen", 32'(ifc.im_w_en), 32'd0);
    chk("rst_waddr", 32'(ifc.im_w_addr), 32'd0);
    chk("rst_wdata", 32'(ifc.im_w_data), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    // back-to-back two-instruction program
    w0 = nw; x0 = nx;
    start();
    status("start", 1, 0, 0, 0, 0);
    inst(8'h34, 8'h12, 8'h01, 1'b0, 0, 5'd0, 17'h11234);
    inst(8'h78, 8'h56, 8'h00, 1'b1, 0, 5'd1, 17'h05678);
    @(posedge clk); #1;
    status("t1", 0, 1, 0, 1, 2);
    chk("t1_nw", 32'(nw - w0), 32'd2);
    chk("t1_nx", 32'(nx - x0), 32'd6);
    // same program with idle gaps between bytes, restarted from DONE
    w0 = nw; x0 = nx;
    start();
    status("t2start", 1, 0, 0, 0, 0);
    inst(8'h34, 8'h12, 8'h01, 1'b0, 3, 5'd0, 17'h11234);
    inst(8'h78, 8'h56, 8'h00, 1'b1, 3, 5'd1, 17'h05678);
    @(posedge clk); #1;
    status("t2", 0, 1, 0, 1, 2);
    chk("t2_nw", 32'(nw - w0), 32'd2);
    chk("t2_nx", 32'(nx - x0), 32'd6);
    // truncated program: last flag on second byte
    w0 = nw;
    start();
    inst(8'h34, 8'h12, 8'h01, 1'b0, 0, 5'd0, 17'h11234);
    send(8'h78, 1'b0, 0);
    send(8'h56, 1'b1, 0);
    status("t3", 0, 1, 1, 1, 1);
    chk("t3_nw", 32'(nw - w0), 32'd1);
    // oversized third byte is truncated and flagged
    start();
    inst(8'h00, 8'h00, 8'hFF, 1'b1, 0, 5'd0, 17'h10000);
    @(posedge clk); #1;
    status("t4", 0, 1, 1, 1, 1);
    // 33-instruction program overflows after 32 writes
    w0 = nw;
    start();
    for (int i = 0; i < 32; i++) inst(8'(i), 8'h00, 8'h00, 1'b0, 0, 5'(i), 17'(i));
    @(posedge clk); #1;
    status("t5", 0, 1, 1, 1, 32);
    chk("t5_nw", 32'(nw - w0), 32'd32);
    x0 = nx;
    ifc.s_valid = 1'b1;
    ifc.s_data = 8'd32;
    ifc.s_last = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("t5_byte97", 32'(nx - x0), 32'd0);
    ifc.s_valid = 1'b0;
    ifc.s_last = 1'b0;
    // asynchronous reset during B1 of the second instruction
    start();
    inst(8'h34, 8'h12, 8'h01, 1'b0, 0, 5'd0, 17'h11234);
    send(8'h78, 1'b0, 0);
    #2 rstn = 1'b1;
    #1;
    status("t6rst", 0, 0, 0, 0, 0);
    chk("t6_ready", 32'(ifc.s_ready), 32'd0);
    chk("t6_wen", 32'(ifc.im_w_en), 32'd0);
    chk("t6_wdata", 32'(ifc.im_w_data), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b0;
    w0 = nw; x0 = nx;
    ifc.s_valid = 1'b1;
    ifc.s_data = 8'h56;
    repeat (4) begin @(posedge clk); #1; end
    ifc.s_valid = 1'b0;
    chk("t6_nw", 32'(nw - w0), 32'd0);
    chk("t6_nx", 32'(nx - x0), 32'd0);
    start();
    inst(8'h34, 8'h12, 8'h01, 1'b0, 0, 5'd0, 17'h11234);
    inst(8'h78, 8'h56, 8'h00, 1'b1, 0, 5'd1, 17'h05678);
    @(posedge clk); #1;
    status("t6", 0, 1, 0, 1, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_loader.md
Name: inst_loader

Overview:
Program loader that is the writer side of the instruction store read by the fetch stage.
- Accepts a byte stream over a valid/ready handshake.
- Assembles little-endian INST_LEN-bit instructions from 3 bytes each.
- Writes them to sequential instruction-memory addresses starting at 0.
- Holds the pipeline in reset while loading, then releases it.

Parameters:
INST_LEN, 17, instruction width in bits; must satisfy 17 <= INST_LEN <= 24.
INST_CAP, 5, instruction-memory address width; capacity is 2^INST_CAP = 32 instructions.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rstn  input  1  reset, asynchronous, active-high (asserted = 1).
load_start  input  1  single-cycle request to begin a load; honoured only when not busy.
s_data  input  8  stream byte.
s_valid  input  1  s_data is valid.
s_last  input  1  qualifies the final byte of the program; meaningful only with s_valid.
s_ready  output  1  loader accepts a byte this cycle.
im_w_en  output  1  instruction-memory write strobe.
im_w_addr  output  INST_CAP  write address.
im_w_data  output  INST_LEN  write data.
busy  output  1  a load is in progress.
done  output  1  the last load finished; held until the next load_start.
err  output  1  sticky error for the current or last load.
count  output  INST_CAP+1  number of instructions written in the current or last load.
pipe_rstn  output  1  active-low reset for the pipeline: 0 = held, 1 = run.

Behaviour:
- Reset (async, any state): state=IDLE, and
  - s_ready=0, im_w_en=0, im_w_addr=0, im_w_data=0;
  - busy=0, done=0, err=0, count=0;
  - pipe_rstn=0, so the pipeline is held after power-up until the first successful load.
- Handshake: a byte transfers on a rising edge where s_valid && s_ready. s_ready is combinational from state only and never depends on s_valid.
- States: IDLE, B0, B1, B2, WRITE, DONE.
- IDLE/DONE:
  - s_ready=0.
  - load_start -> B0. On the next edge: busy=1, done=0, err=0, count=0, pipe_rstn=0.
- B0, B1:
  - s_ready=1.
  - On transfer, the byte goes into assembly bits [7:0] (B0) or [15:8] (B1).
  - If s_last is set on that transfer: err=1, the partial instruction is discarded, -> DONE.
  - Otherwise advance to the next state.
- B2:
  - s_ready=1.
  - On transfer, s_data[INST_LEN-17:0] becomes bits [INST_LEN-1:16].
  - Any nonzero s_data[7:INST_LEN-16] sets err=1; the instruction is still written, truncated.
  - Latch s_last, then -> WRITE.
- WRITE:
  - s_ready=0.
  - Registered outputs for exactly one cycle: im_w_en=1, im_w_addr=count[INST_CAP-1:0], im_w_data=assembled word.
  - count increments on the same edge that deasserts im_w_en.
  - Next state:
    - latched last -> DONE;
    - else count (post-increment) == 2^INST_CAP -> DONE with err=1 (overflow, program not terminated);
    - else -> B0.
- Entering DONE: busy=0, done=1, pipe_rstn=1 from the next cycle on, regardless of err.
- Bytes offered while in IDLE, DONE or WRITE are not accepted (s_ready=0); the source holds them.
- load_start while busy is ignored. load_start in DONE restarts, driving pipe_rstn=0 again.
- Throughput: at most 1 instruction per 4 cycles. Latency from the third byte's transfer edge to im_w_en high is 1 cycle.
- Reset mid-load: the load is abandoned, nothing further is written, outputs return to reset values, and pipe_rstn=0.

Decomposition:
- Shared package holds:
  - state enum {IDLE,B0,B1,B2,WRITE,DONE};
  - localparam BYTES_PER_INST=3;
  - localparam CAP=2^INST_CAP.
- Single module; no sub-module. The byte assembler is a 24-bit shift/insert register inside the FSM.

Test Plan:
- Reset, then load_start, then bytes 34,12,01 and 78,56,00 (last) with s_valid held high. Expect:
  - im_w_en pulses at addr 0 data 0x11234 and at addr 1 data 0x05678;
  - count=2, done=1, err=0, pipe_rstn=1;
  - each write exactly 1 cycle after its third byte.
- Same program with s_valid deasserted for 3 cycles between every byte. Expect identical writes, and no byte accepted while s_valid=0 or in WRITE.
- s_last on the second byte of instruction 1. Expect:
  - instruction 0 written, instruction 1 not written;
  - err=1, count=1, done=1, pipe_rstn=1.
- Third byte 0xFF with INST_LEN=17. Expect im_w_data[16]=1 and err=1.
- 33 instructions, last flag on the 33rd. Expect 32 writes (addr 0..31), DONE after the 32nd with err=1, and byte 97 never accepted.
- Assert rstn during B1 of the second instruction. Expect:
  - all outputs at reset values immediately (async), pipe_rstn=0;
  - no further im_w_en;
  - a fresh load then succeeds from addr 0.
